// File: rtl/swipt_link_tx.sv
// SWIPT link transmit carrier: frequency command -> half-period via a restoring divider,
// phase-continuous square-wave generation and a settle indicator for the receiver PLL.
module swipt_link_tx #(
  parameter int unsigned CLK_HZ         = 100000000,
  parameter int unsigned F_MIN          = 20000,
  parameter int unsigned F_MAX          = 100000,
  parameter int unsigned F_DEFAULT      = 40000,
  parameter int unsigned SETTLE_PERIODS = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        swiptAlive,
  input  logic [31:0] f_in,
  input  logic        f_valid,
  output logic        f_ready,
  output logic        link,
  output logic        freq_rdy,
  output logic [31:0] f_active,
  output logic        busy,
  output logic        err
);

  localparam logic [31:0] HalfDefault = 32'(CLK_HZ / (2 * F_DEFAULT));
  localparam logic [31:0] ClkHz       = 32'(CLK_HZ);
  localparam logic [31:0] FMin        = 32'(F_MIN);
  localparam logic [31:0] FMax        = 32'(F_MAX);
  localparam logic [31:0] FDefault    = 32'(F_DEFAULT);
  localparam logic [15:0] SettleMax   = 16'(SETTLE_PERIODS);

  typedef enum logic [1:0] {
    StIdle,
    StDivide,
    StPend
  } state_e;

  // Control / divider state
  state_e      state_q, state_d;
  logic [31:0] f_req_q, f_req_d;
  logic [32:0] divisor_q, divisor_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] quot_q, quot_d;
  logic [4:0]  iter_q, iter_d;
  logic        err_q, err_d;

  // Carrier state
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] half_q, half_d;
  logic        link_q, link_d;
  logic [31:0] f_active_q, f_active_d;
  logic [15:0] settle_q, settle_d;
  logic        frdy_q, frdy_d;

  logic        in_range;
  logic        pend;
  logic        rise;
  logic        apply;
  logic [32:0] rem_shift;

  assign in_range = (f_in >= FMin) && (f_in <= FMax);
  assign pend     = (state_q == StPend);
  assign rise     = swiptAlive && (cnt_q == 32'd0) && !link_q;
  // A pending value lands on a rising carrier edge, or at once while the carrier is off.
  assign apply    = pend && (rise || !swiptAlive);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= StIdle;
      f_req_q    <= FDefault;
      divisor_q  <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      quot_q     <= '0;
      iter_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= HalfDefault - 32'd1;
      half_q     <= HalfDefault;
      link_q     <= 1'b0;
      f_active_q <= FDefault;
      settle_q   <= '0;
      frdy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      f_req_q    <= f_req_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      quot_q     <= quot_d;
      iter_q     <= iter_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      link_q     <= link_d;
      f_active_q <= f_active_d;
      settle_q   <= settle_d;
      frdy_q     <= frdy_d;
    end
  end

  // Command handshake and restoring divider, one quotient bit per cycle.
  always_comb begin
    state_d   = state_q;
    f_req_d   = f_req_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    quot_d    = quot_q;
    iter_d    = iter_q;
    err_d     = 1'b0;
    rem_shift = {rem_q[31:0], dvd_q[31]};

    unique case (state_q)
      StIdle: begin
        if (f_valid) begin
          if (in_range) begin
            f_req_d   = f_in;
            divisor_d = {f_in, 1'b0};
            rem_d     = '0;
            dvd_d     = ClkHz;
            quot_d    = '0;
            iter_d    = '0;
            state_d   = StDivide;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StDivide: begin
        if (rem_shift >= divisor_q) begin
          rem_d  = rem_shift - divisor_q;
          quot_d = {quot_q[30:0], 1'b1};
        end else begin
          rem_d  = rem_shift;
          quot_d = {quot_q[30:0], 1'b0};
        end
        dvd_d  = {dvd_q[30:0], 1'b0};
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'd31) begin
          state_d = StPend;
        end
      end
      StPend: begin
        if (apply) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Carrier down-counter, phase-continuous half-period update and settle tracking.
  always_comb begin
    cnt_d      = cnt_q;
    half_d     = half_q;
    link_d     = link_q;
    f_active_d = f_active_q;
    settle_d   = settle_q;
    frdy_d     = frdy_q;

    if (!swiptAlive) begin
      link_d   = 1'b0;
      frdy_d   = 1'b0;
      settle_d = '0;
      if (apply) begin
        half_d     = quot_q;
        cnt_d      = quot_q - 32'd1;
        f_active_d = f_req_q;
      end else begin
        cnt_d = half_q - 32'd1;
      end
    end else if (cnt_q == 32'd0) begin
      link_d = ~link_q;
      cnt_d  = half_q - 32'd1;
      if (apply) begin
        half_d     = quot_q;
        cnt_d      = quot_q - 32'd1;
        f_active_d = f_req_q;
        settle_d   = '0;
        frdy_d     = 1'b0;
      end else if (rise) begin
        if (settle_q < SettleMax) begin
          settle_d = settle_q + 16'd1;
        end
        frdy_d = (settle_d >= SettleMax);
      end
    end else begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  assign f_ready  = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign err      = err_q;
  assign link     = link_q;
  assign freq_rdy = frdy_q;
  assign f_active = f_active_q;

endmodule

// File: tb/tb_swipt_link_tx.sv
// Bench for swipt_link_tx: event-level carrier model compared every cycle, plus directed
// scenarios with hand-computed half-periods (1250, 1219, 833) and pulse checks.
module tb_swipt_link_tx;

  localparam int unsigned ClkHz  = 100000000;
  localparam int unsigned FMin   = 20000;
  localparam int unsigned FMax   = 100000;
  localparam int unsigned FDef   = 40000;
  localparam int          Settle = 4;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        swiptAlive = 1'b1;
  logic [31:0] f_in = '0;
  logic        f_valid = 1'b0;
  logic        f_ready;
  logic        link;
  logic        freq_rdy;
  logic [31:0] f_active;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  swipt_link_tx #(
    .CLK_HZ        (ClkHz),
    .F_MIN         (FMin),
    .F_MAX         (FMax),
    .F_DEFAULT     (FDef),
    .SETTLE_PERIODS(Settle)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .swiptAlive(swiptAlive),
    .f_in      (f_in),
    .f_valid   (f_valid),
    .f_ready   (f_ready),
    .link      (link),
    .freq_rdy  (freq_rdy),
    .f_active  (f_active),
    .busy      (busy),
    .err       (err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the carrier is a sequence of half-periods; a command becomes usable 32 edges after
  // acceptance and replaces the half-period at the next rising edge (or immediately when off).
  logic        m_link, m_frdy, m_err, m_busy, m_ready;
  logic [31:0] m_phase, m_half, m_factive, m_req;
  int          m_settle, m_age;

  task automatic model_reset();
    m_link    = 1'b0;
    m_frdy    = 1'b0;
    m_err     = 1'b0;
    m_busy    = 1'b0;
    m_phase   = '0;
    m_half    = ClkHz / (2 * FDef);
    m_settle  = 0;
    m_age     = 0;
    m_factive = FDef;
    m_req     = '0;
  endtask

  task automatic model_apply();
    m_half    = ClkHz / (2 * m_req);
    m_factive = m_req;
    m_busy    = 1'b0;
    m_settle  = 0;
    m_frdy    = 1'b0;
  endtask

  task automatic model_step();
    m_ready = m_busy && (m_age >= 32);
    m_err   = 1'b0;
    if (m_busy) begin
      m_age++;
    end else if (f_valid) begin
      if (f_in >= FMin && f_in <= FMax) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_req  = f_in;
      end else begin
        m_err = 1'b1;
      end
    end
    if (!swiptAlive) begin
      m_link   = 1'b0;
      m_phase  = '0;
      m_frdy   = 1'b0;
      m_settle = 0;
      if (m_ready) model_apply();
    end else begin
      m_phase++;
      if (m_phase == m_half) begin
        m_phase = '0;
        m_link  = !m_link;
        if (m_link) begin
          if (m_ready) begin
            model_apply();
          end else begin
            if (m_settle < Settle) m_settle++;
            m_frdy = (m_settle >= Settle);
          end
        end
      end
    end
  endtask

  always @(posedge clk or negedge nrst) begin
    if (!nrst) model_reset();
    else       model_step();
  end

  // Per-cycle comparison and carrier edge measurement.
  longint cyc = 0;
  longint last_toggle = 0;
  longint last_half = 0;
  int     rises = 0;
  logic   prev_link = 1'b0;

  always @(negedge clk) begin
    cyc++;
    check("outputs", 64'({link, freq_rdy, f_ready, busy, err, f_active}),
          64'({m_link, m_frdy, !m_busy, m_busy, m_err, m_factive}));
    if (link !== prev_link) begin
      last_half   = cyc - last_toggle;
      last_toggle = cyc;
      if (link === 1'b1) rises++;
    end
    prev_link = link;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Offers f and holds f_valid until accepted; returns the number of cycles spent waiting.
  task automatic send(input logic [31:0] f, input int max_wait, output int waited);
    logic acc;
    acc     = 1'b0;
    waited  = 0;
    f_in    = f;
    f_valid = 1'b1;
    while (!acc && waited < max_wait) begin
      acc = f_ready;
      step();
      waited++;
    end
    f_valid = 1'b0;
    check("send_accepted", 64'(acc), 64'd1);
  endtask

  task automatic wait_frdy(input string name, input int max_wait);
    int n;
    n = 0;
    while (freq_rdy !== 1'b1 && n < max_wait) begin
      step();
      n++;
    end
    check(name, 64'(freq_rdy), 64'd1);
  endtask

  initial begin
    int n;
    int r0;
    int waited;

    // Reset values
    repeat (3) step();
    check("rst_link", 64'(link), 64'd0);
    check("rst_f_active", 64'(f_active), 64'd40000);
    check("rst_f_ready", 64'(f_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_freq_rdy", 64'(freq_rdy), 64'd0);

    // Default carrier
    r0 = rises;
    nrst = 1'b1;
    wait_frdy("default_settle", 12000);
    check("default_half", 64'(last_half), 64'd1250);
    check("default_rises_at_rdy", 64'(rises - r0), 64'd4);

    // Out-of-range commands
    send(32'd10000, 5, waited);
    check("err_lo_pulse", 64'(err), 64'd1);
    step();
    check("err_lo_clear", 64'(err), 64'd0);
    check("oor_f_ready", 64'(f_ready), 64'd1);
    send(32'd200000, 5, waited);
    check("err_hi_pulse", 64'(err), 64'd1);
    step();
    check("err_hi_clear", 64'(err), 64'd0);
    check("oor_f_active", 64'(f_active), 64'd40000);
    check("oor_freq_rdy", 64'(freq_rdy), 64'd1);

    // Frequency change to 41000 Hz
    send(32'd41000, 5, waited);
    check("chg_busy", 64'(busy), 64'd1);
    n = 1;
    while (busy === 1'b1 && n < 5000) begin
      step();
      n++;
    end
    check("chg_busy_ge33", 64'(n >= 33), 64'd1);
    check("chg_applied_on_rise", 64'(link), 64'd1);
    check("chg_f_active", 64'(f_active), 64'd41000);
    check("chg_frdy_low", 64'(freq_rdy), 64'd0);
    wait_frdy("chg_settle", 11000);
    check("chg_half", 64'(last_half), 64'd1219);

    // Back-pressure: 60000 held while 41000 is in flight
    send(32'd41000, 5, waited);
    send(32'd60000, 5000, waited);
    check("bp_wait_ge33", 64'(waited >= 33), 64'd1);
    check("bp_busy", 64'(busy), 64'd1);
    check("bp_f_active_prev", 64'(f_active), 64'd41000);
    wait_frdy("bp_settle", 12000);
    check("bp_f_active", 64'(f_active), 64'd60000);
    check("bp_half", 64'(last_half), 64'd833);

    // Carrier disable while a value sits in PEND
    send(32'd41000, 5, waited);
    repeat (32) step();
    check("dis_pend_busy", 64'(busy), 64'd1);
    check("dis_pend_f_active", 64'(f_active), 64'd60000);
    swiptAlive = 1'b0;
    step();
    check("dis_link", 64'(link), 64'd0);
    check("dis_freq_rdy", 64'(freq_rdy), 64'd0);
    check("dis_f_active", 64'(f_active), 64'd41000);
    check("dis_idle", 64'(f_ready), 64'd1);
    repeat (20) step();
    swiptAlive = 1'b1;
    n = 0;
    while (link !== 1'b1 && n < 5000) begin
      step();
      n++;
    end
    check("realive_first_rise", 64'(n), 64'd1219);

    // Asynchronous reset in the middle of a division
    send(32'd60000, 5, waited);
    repeat (9) step();
    #2 nrst = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_f_ready", 64'(f_ready), 64'd1);
    check("arst_f_active", 64'(f_active), 64'd40000);
    check("arst_link", 64'(link), 64'd0);
    check("arst_freq_rdy", 64'(freq_rdy), 64'd0);
    @(negedge clk);
    #2 nrst = 1'b1;
    n = 0;
    while (link !== 1'b1 && n < 5000) begin
      step();
      n++;
    end
    check("arst_first_rise", 64'(n), 64'd1250);
    check("arst_post_f_ready", 64'(f_ready), 64'd1);
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/swipt_link_tx.md
# swipt_link_tx

- Transmit-side carrier generator for the SWIPT link.
- Accepts a carrier frequency command in Hz through a valid/ready handshake and converts it to a half-period in clock cycles with a sequential divider.
- Drives the square-wave `link` signal that the receiver PLL tracks, with phase-continuous frequency changes.
- Asserts `freq_rdy` once the new frequency has been stable for a set number of carrier periods.

## Interface
- `CLK_HZ`, 100000000, system clock frequency in Hz
- `F_MIN`, 20000, lowest accepted carrier frequency (Hz)
- `F_MAX`, 100000, highest accepted carrier frequency (Hz)
- `F_DEFAULT`, 40000, carrier frequency after reset (Hz)
- `SETTLE_PERIODS`, 4, full carrier periods at the new frequency before `freq_rdy` asserts
- `clk`  in  1  system clock; one clock domain, all logic on its rising edge
- `nrst`  in  1  reset, asynchronous, active-low
- `swiptAlive`  in  1  carrier enable; low silences the carrier
- `f_in`  in  32  requested carrier frequency, unsigned Hz
- `f_valid`  in  1  `f_in` valid
- `f_ready`  out  1  block can accept a command
- `link`  out  1  carrier square wave
- `freq_rdy`  out  1  carrier settled at `f_active`
- `f_active`  out  32  frequency currently driven on `link` (requested value, Hz)
- `busy`  out  1  divider running or result pending
- `err`  out  1  one-cycle pulse: rejected command

## Operation
- Reset values:
  - `link`=0, `freq_rdy`=0, `f_active`=`F_DEFAULT`, `f_ready`=1, `busy`=0, `err`=0.
  - Half-period register = floor(`CLK_HZ`/(2·`F_DEFAULT`)) (1250 by default), computed at elaboration.
  - Settle counter = 0.
- Control FSM states:
  - IDLE: `f_ready`=1. A handshake (`f_valid`&&`f_ready`) with `f_in` inside [`F_MIN`,`F_MAX`] latches `f_in`, computes the divisor 2·`f_in`, and goes to DIVIDE.
  - Out-of-range `f_in`: pulse `err` for exactly 1 cycle, stay in IDLE, change nothing else.
  - DIVIDE: 32-iteration restoring division of `CLK_HZ` by 2·`f_in`, one quotient bit per cycle, floor result. Goes to PEND.
  - PEND: quotient held as the pending half-period. Returns to IDLE in the cycle the pending value is applied.
  - `f_ready`=0 and `busy`=1 in DIVIDE and PEND. `f_valid` is ignored there; no queueing.
- Carrier generator:
  - Down-counter loaded with half-period−1. `link` toggles when it reaches 0, then the counter reloads.
  - A pending half-period is applied only at a 0→1 toggle of `link` (phase-continuous). `f_active` updates in the same cycle.
  - At that toggle `freq_rdy` drops to 0 and the settle counter clears.
- Settle counter:
  - Counts 0→1 toggles of `link` after an application.
  - `freq_rdy`=1 once the count reaches `SETTLE_PERIODS`. It then holds until the next application, `swiptAlive` low, or reset.
  - Saturates; no wrap.
- `swiptAlive` low:
  - `link` forced 0, counter held at reload value, `freq_rdy`=0, settle counter cleared.
  - A value in PEND is applied immediately, next cycle.
  - The handshake and divider still operate.
- `swiptAlive` rising: the first `link` 0→1 occurs one half-period later, at the new (or current) half-period.
- Arithmetic:
  - Divisor 33 bits, remainder 33 bits, quotient 32 bits; no overflow possible within the parameter ranges.
  - Half-period is never below 2 for legal parameters. `F_MAX` ≤ `CLK_HZ`/4 is a parameter-legality requirement.
- `nrst` low at any time aborts DIVIDE/PEND and restores all reset values asynchronously.

## Timing
- Handshake at edge k: DIVIDE occupies edges k+1..k+32; PEND entered and `busy` still 1 at k+33.
- Application latency: from k+33 to the next carrier 0→1 toggle. Worst case one full old period plus 1 cycle.
- `err` high in cycle k+1 only.
- `link` half-period in cycles equals the half-period register exactly; each toggle is a registered output.
- `freq_rdy` rises in the same cycle as the `SETTLE_PERIODS`-th 0→1 toggle after application.

## Test plan
- Reset and default carrier:
  - Stimulus: release `nrst` with `swiptAlive`=1.
  - Required: `link` toggles every 1250 cycles; `f_active`=40000; `freq_rdy` rises at the 4th rising edge of `link`.
- Frequency change:
  - Stimulus: command 41000 (0xA028).
  - Required: `busy` for ≥33 cycles; the new half-period 1219 is applied only at a `link` 0→1; no shortened/glitch half-period; `freq_rdy` low then high after 4 periods of 2438 cycles.
- Out-of-range:
  - Stimulus: commands 10000 and 200000.
  - Required: `err` 1-cycle pulse each; `f_active`, `link` timing, and `freq_rdy` unchanged; `f_ready` stays 1.
- Back-pressure:
  - Stimulus: hold `f_valid` with 60000 while DIVIDE/PEND for 41000 is in progress.
  - Required: 60000 is not accepted until `f_ready` returns, then applied next. Final half-period 833.
- Carrier disable:
  - Stimulus: drop `swiptAlive` with a value in PEND.
  - Required: `link`=0 next cycle; `freq_rdy`=0; `f_active` updates within 1 cycle.
  - Stimulus: re-raise `swiptAlive`. Required: first `link` rise after one new half-period.
- Asynchronous reset mid-division:
  - Stimulus: pulse `nrst` low in DIVIDE cycle 10.
  - Required: immediate reset values; afterwards the 1250-cycle half-period and `f_ready`=1.
